// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and modulo pointer arithmetic for the FIFOs
//
// Purpose: width functions (CW, PTR_W, CNT_W) and wrap_add(), used by every FIFO in the slice.
// wrap_add() assumes n <= depth, so one conditional subtract is a full modulo.
package fifo_pkg;

   // Width of a per-cycle word count that can hold 0..max(pw,pr)
   function automatic int cw_f(input int pw, input int pr);
      return $clog2(((pw > pr) ? pw : pr) + 1);
   endfunction

   // Width of a pointer into depth slots (at least one bit)
   function automatic int ptr_w_f(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of an occupancy counter holding 0..depth
   function automatic int cnt_w_f(input int depth);
      return $clog2(depth + 1);
   endfunction

   // (ptr + n) mod depth for ptr < depth and n <= depth; depth need not be a power of two
   function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned n,
                                            input int unsigned depth);
      int unsigned s;
      s = ptr + n;
      if (s >= depth) s = s - depth;
      return s;
   endfunction

endpackage

// File: rtl/multiport_ram.sv
// rtl/multiport_ram.sv - DEPTH x DATA_WIDTH storage with masked write lanes and async read lanes
//
// Ports:
//   clk    - write clock
//   we     - per-lane write enable (NW lanes)
//   waddr  - per-lane write address, lane i in waddr[i*AW +: AW]
//   wdata  - per-lane write data, lane i in wdata[i*DATA_WIDTH +: DATA_WIDTH]
//   raddr  - per-lane read address (NR lanes)
//   rdata  - combinational read data per lane
// Storage is deliberately not reset.
module multiport_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int NW         = 4,
   parameter int NR         = 2,
   parameter int AW         = 4
) (
   input  logic                     clk,
   input  logic [NW-1:0]            we,
   input  logic [NW*AW-1:0]         waddr,
   input  logic [NW*DATA_WIDTH-1:0] wdata,
   input  logic [NR*AW-1:0]         raddr,
   output logic [NR*DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Active lanes always carry distinct addresses, so lane order never matters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NW; i++) begin
         if (we[i]) mem[waddr[i*AW +: AW]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      rdata = '0;
      for (int j = 0; j < NR; j++) begin
         rdata[j*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[j*AW +: AW]];
      end
   end

endmodule

// File: rtl/multiport_fifo.sv
// rtl/multiport_fifo.sv - circular FIFO with variable-width write (1..PAR_WRITE) and read (1..PAR_READ)
//
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   clear                - synchronous flush of pointers, count and sticky flags
//   wen, wnum, din       - write request of wnum words; word 0 of din is oldest
//   ren, rnum            - pop request of rnum words
//   dout, dout_valid     - show-ahead view of the PAR_READ oldest entries, bit i valid when count > i
//   count                - occupancy (all DEPTH slots usable)
//   wready               - room for a full PAR_WRITE write
//   full, empty, almost_full, almost_empty - combinational from count
//   overflow, underflow  - sticky: a write / read was refused
module multiport_fifo
   import fifo_pkg::*;
#(
   parameter int  DATA_WIDTH = 16,
   parameter int  PAR_WRITE  = 4,
   parameter int  PAR_READ   = 2,
   parameter int  DEPTH      = 16,
   parameter int  AF_LEVEL   = 12,
   parameter int  AE_LEVEL   = 2,
   localparam int CW         = cw_f(PAR_WRITE, PAR_READ),
   localparam int PTR_W      = ptr_w_f(DEPTH),
   localparam int CNT_W      = cnt_w_f(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           clear,
   input  logic                           wen,
   input  logic [CW-1:0]                  wnum,
   input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
   input  logic                           ren,
   input  logic [CW-1:0]                  rnum,
   output logic [PAR_READ*DATA_WIDTH-1:0] dout,
   output logic [PAR_READ-1:0]            dout_valid,
   output logic [CNT_W-1:0]               count,
   output logic                           wready,
   output logic                           full,
   output logic                           empty,
   output logic                           almost_full,
   output logic                           almost_empty,
   output logic                           overflow,
   output logic                           underflow
);

   logic [PTR_W-1:0]           rptr;
   logic [PTR_W-1:0]           wptr;
   logic                       write_ok;
   logic                       read_ok;
   logic                       write_req;
   logic                       read_req;
   logic [PAR_WRITE-1:0]       we;
   logic [PAR_WRITE*PTR_W-1:0] waddr;
   logic [PAR_READ*PTR_W-1:0]  raddr;

   // A zero-length request is a no-op: it neither transfers nor raises a sticky flag.
   assign write_req = wen && (wnum != '0);
   assign read_req  = ren && (rnum != '0);

   // Acceptance looks only at pre-edge occupancy; there is no write-to-read bypass.
   assign write_ok = write_req && (int'(wnum) <= PAR_WRITE) && (int'(wnum) <= DEPTH - int'(count));
   assign read_ok  = read_req && (int'(rnum) <= PAR_READ) && (int'(rnum) <= int'(count));

   always_comb begin
      we    = '0;
      waddr = '0;
      for (int i = 0; i < PAR_WRITE; i++) begin
         waddr[i*PTR_W +: PTR_W] = PTR_W'(wrap_add(32'(wptr), i, DEPTH));
         we[i]                   = write_ok && (i < int'(wnum));
      end
   end

   always_comb begin
      raddr = '0;
      for (int j = 0; j < PAR_READ; j++) begin
         raddr[j*PTR_W +: PTR_W] = PTR_W'(wrap_add(32'(rptr), j, DEPTH));
      end
   end

   multiport_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .NW         (PAR_WRITE),
      .NR         (PAR_READ),
      .AW         (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (din),
      .raddr (raddr),
      .rdata (dout)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rptr      <= '0;
         wptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         rptr      <= '0;
         wptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (write_ok) wptr <= PTR_W'(wrap_add(32'(wptr), 32'(wnum), DEPTH));
         if (read_ok)  rptr <= PTR_W'(wrap_add(32'(rptr), 32'(rnum), DEPTH));
         count <= count + (write_ok ? CNT_W'(wnum) : '0) - (read_ok ? CNT_W'(rnum) : '0);
         if (write_req && !write_ok) overflow  <= 1'b1;
         if (read_req && !read_ok)   underflow <= 1'b1;
      end
   end

   always_comb begin
      dout_valid = '0;
      for (int k = 0; k < PAR_READ; k++) begin
         dout_valid[k] = (int'(count) > k);
      end
   end

   assign wready       = (DEPTH - int'(count)) >= PAR_WRITE;
   assign full         = (int'(count) == DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);

endmodule

// File: tb/tb_multiport_fifo.sv
// tb/tb_multiport_fifo.sv - scoreboard bench for multiport_fifo
module tb_multiport_fifo;
   localparam int DW    = 16;
   localparam int PW    = 4;
   localparam int PR    = 2;
   localparam int D     = 16;
   localparam int CW    = 3;
   localparam int CNT_W = 5;

   logic             clk   = 1'b0;
   logic             rstn  = 1'b0;
   logic             clear = 1'b0;
   logic             wen   = 1'b0;
   logic             ren   = 1'b0;
   logic [CW-1:0]    wnum  = '0;
   logic [CW-1:0]    rnum  = '0;
   logic [PW*DW-1:0] din   = '0;
   logic [PR*DW-1:0] dout;
   logic [PR-1:0]    dout_valid;
   logic [CNT_W-1:0] count;
   logic             wready, full, empty, almost_full, almost_empty, overflow, underflow;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [15:0] exp_q[$];
   int         mdl_cnt = 0;
   bit         mdl_ovf = 0;
   bit         mdl_unf = 0;
   bit         wr_acc  = 0;
   bit         rd_acc  = 0;
   int         rd_n    = 0;
   bit         mon_en  = 0;

   always #5 clk = ~clk;

   multiport_fifo #(
      .DATA_WIDTH (DW), .PAR_WRITE (PW), .PAR_READ (PR), .DEPTH (D), .AF_LEVEL (12), .AE_LEVEL (2)
   ) dut (
      .clk (clk), .rstn (rstn), .clear (clear),
      .wen (wen), .wnum (wnum), .din (din),
      .ren (ren), .rnum (rnum),
      .dout (dout), .dout_valid (dout_valid), .count (count),
      .wready (wready), .full (full), .empty (empty),
      .almost_full (almost_full), .almost_empty (almost_empty),
      .overflow (overflow), .underflow (underflow)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack4(input logic [15:0] w0, input logic [15:0] w1,
                                         input logic [15:0] w2, input logic [15:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   // Monitor: compares every cycle against the model, pops the scoreboard on accepted reads
   always @(negedge clk) begin
      if (mon_en && rstn) begin
         check("count",        count,        mdl_cnt);
         check("empty",        empty,        mdl_cnt == 0);
         check("full",         full,         mdl_cnt == D);
         check("wready",       wready,       (D - mdl_cnt) >= PW);
         check("almost_full",  almost_full,  mdl_cnt >= 12);
         check("almost_empty", almost_empty, mdl_cnt <= 2);
         check("dout_valid",   dout_valid,   {mdl_cnt > 1, mdl_cnt > 0});
         check("overflow",     overflow,     mdl_ovf);
         check("underflow",    underflow,    mdl_unf);
         if (rd_acc) begin
            for (int i = 0; i < rd_n; i++) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL scoreboard_empty: read accepted with no expected data at %0t", $time);
               end else begin
                  check($sformatf("dout_word%0d", i), dout[i*DW +: DW], exp_q.pop_front());
               end
            end
         end
      end
   end

   // One clock of stimulus; the model updates after the edge it describes
   task automatic step(input bit w, input int wn, input logic [63:0] d,
                       input bit r, input int rn, input bit clr);
      wen   = w;
      wnum  = CW'(wn);
      din   = d;
      ren   = r;
      rnum  = CW'(rn);
      clear = clr;
      wr_acc = !clr && w && wn > 0 && wn <= PW && wn <= D - mdl_cnt;
      rd_acc = !clr && r && rn > 0 && rn <= PR && rn <= mdl_cnt;
      rd_n   = rn;
      @(posedge clk);
      #1;
      if (clr) begin
         mdl_cnt = 0;
         mdl_ovf = 0;
         mdl_unf = 0;
         exp_q.delete();
      end else begin
         if (w && wn > 0 && !wr_acc) mdl_ovf = 1;
         if (r && rn > 0 && !rd_acc) mdl_unf = 1;
         if (wr_acc) begin
            for (int i = 0; i < wn; i++) exp_q.push_back(d[i*DW +: DW]);
            mdl_cnt += wn;
         end
         if (rd_acc) mdl_cnt -= rn;
      end
      wen = 0; ren = 0; clear = 0; wr_acc = 0; rd_acc = 0;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_count",  count, 0);
      check("rst_empty",  empty, 1);
      check("rst_ae",     almost_empty, 1);
      check("rst_wready", wready, 1);
      check("rst_full",   full, 0);
      check("rst_af",     almost_full, 0);
      check("rst_dvalid", dout_valid, 2'b00);
      check("rst_ovf",    overflow, 0);
      check("rst_unf",    underflow, 0);
      rstn   = 1;
      mon_en = 1;

      // 1: single write of 4 words
      step(1, 4, pack4(16'h11, 16'h12, 16'h13, 16'h14), 0, 0, 0);
      check("t1_count",  count, 4);
      check("t1_dout",   dout, 32'h0012_0011);
      check("t1_dvalid", dout_valid, 2'b11);
      check("t1_ae",     almost_empty, 0);
      step(0, 0, '0, 1, 2, 0);
      step(0, 0, '0, 1, 2, 0);

      // 2: fill to full, then a refused write
      for (int k = 0; k < 4; k++)
         step(1, 4, pack4(16'h21 + 16'(4*k), 16'h22 + 16'(4*k), 16'h23 + 16'(4*k), 16'h24 + 16'(4*k)),
              0, 0, 0);
      check("t2_full",   full, 1);
      check("t2_wready", wready, 0);
      step(1, 1, pack4(16'hdead, 0, 0, 0), 0, 0, 0);
      check("t2_ovf",    overflow, 1);
      check("t2_count",  count, 16);
      for (int k = 0; k < 8; k++) step(0, 0, '0, 1, 2, 0);
      check("t2_empty",  empty, 1);

      // 3: concurrent wnum=3 / rnum=2 across the pointer wrap
      for (int k = 0; k < 10; k++)
         step(1, 3, pack4(16'h100 + 16'(3*k), 16'h101 + 16'(3*k), 16'h102 + 16'(3*k), 16'hffff),
              1, 2, 0);
      check("t3_count", count, 12);
      for (int k = 0; k < 6; k++) step(0, 0, '0, 1, 2, 0);

      // zero-length requests are no-ops after a flush
      step(0, 0, '0, 0, 0, 1);
      step(1, 0, pack4(16'hbad0, 0, 0, 0), 1, 0, 0);
      check("nop_ovf", overflow, 0);
      check("nop_unf", underflow, 0);

      // 4: underflow at count=1
      step(1, 1, pack4(16'h41, 0, 0, 0), 0, 0, 0);
      step(0, 0, '0, 1, 2, 0);
      check("t4_unf",   underflow, 1);
      check("t4_count", count, 1);
      step(0, 0, '0, 1, 1, 0);
      check("t4_empty", empty, 1);

      // 5: write and read together on an empty FIFO
      step(0, 0, '0, 0, 0, 1);
      step(1, 2, pack4(16'h51, 16'h52, 0, 0), 1, 1, 0);
      check("t5_count", count, 2);
      check("t5_unf",   underflow, 1);

      // 6: clear with a concurrent write at count=9
      step(1, 4, pack4(16'h61, 16'h62, 16'h63, 16'h64), 0, 0, 0);
      step(1, 3, pack4(16'h65, 16'h66, 16'h67, 0), 0, 0, 0);
      check("t6_count9", count, 9);
      step(1, 4, pack4(16'h71, 16'h72, 16'h73, 16'h74), 0, 0, 1);
      check("t6_clr_count", count, 0);
      check("t6_clr_unf",   underflow, 0);
      check("t6_clr_empty", empty, 1);

      // 6: asynchronous reset mid-burst
      step(0, 0, '0, 1, 1, 0);
      step(1, 4, pack4(16'h81, 16'h82, 16'h83, 16'h84), 0, 0, 0);
      mon_en = 0;
      wen  = 1;
      wnum = 3'd4;
      din  = pack4(16'h85, 16'h86, 16'h87, 16'h88);
      @(posedge clk);
      #1;
      check("t6_pre_count", count, 8);
      check("t6_pre_unf",   underflow, 1);
      #2 rstn = 0;
      #1;
      check("t6_async_count",  count, 0);
      check("t6_async_empty",  empty, 1);
      check("t6_async_ae",     almost_empty, 1);
      check("t6_async_wready", wready, 1);
      check("t6_async_dvalid", dout_valid, 2'b00);
      check("t6_async_unf",    underflow, 0);
      wen = 0;
      mdl_cnt = 0; mdl_ovf = 0; mdl_unf = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("t6_hold_count", count, 0);
      rstn   = 1;
      mon_en = 1;
      step(1, 2, pack4(16'h91, 16'h92, 0, 0), 0, 0, 0);
      step(0, 0, '0, 1, 2, 0);
      step(0, 0, '0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
